// File: rtl/aes_round_sequencer_if.sv
// Start/done handshake, key-schedule handshake and datapath stage controls
// of the AES-128 round sequencer. The sequencer connects through the slave modport.
interface aes_round_sequencer_if #(
    parameter int MIX_CYCLES = 4
);
    localparam int MCW = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;

    logic           start;
    logic           abort;
    logic           key_valid;
    logic           busy;
    logic           done;
    logic [3:0]     round;
    logic           ld_state;
    logic           sub_en;
    logic           shift_en;
    logic           mix_en;
    logic [MCW-1:0] mix_col;
    logic           ark_en;
    logic           key_req;

    modport master (
        output start, abort, key_valid,
        input  busy, done, round, ld_state, sub_en, shift_en, mix_en, mix_col,
               ark_en, key_req
    );

    modport slave (
        input  start, abort, key_valid,
        output busy, done, round, ld_state, sub_en, shift_en, mix_en, mix_col,
               ark_en, key_req
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES-128 encrypt datapath.
// Build option AES_KEY_WAIT_EN: stall in the AddRoundKey states until key_valid.
//
// state   | meaning
// IDLE    | waiting for start; ld_state follows start
// ARK0    | initial AddRoundKey with key 0
// SUB     | SubBytes for `round`
// SHIFT   | ShiftRows for `round`
// MIX     | MixColumns, one column per cycle (mix_col)
// ARK     | AddRoundKey with key `round`
// DONE    | one-cycle done pulse, ciphertext in state register
module aes_round_sequencer #(
    parameter int NR         = 10,
    parameter int MIX_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_sequencer_if.slave  bus
);
    localparam int             MCW      = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;
    localparam logic [3:0]     NR_L     = 4'(NR);
    localparam logic [MCW-1:0] MIX_LAST = MCW'(MIX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARK0,
        S_SUB,
        S_SHIFT,
        S_MIX,
        S_ARK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [MCW-1:0] mix_col_q, mix_col_d;
    logic           key_ok;

`ifdef AES_KEY_WAIT_EN
    assign key_ok = bus.key_valid;
`else
    logic unused_key_valid;
    assign unused_key_valid = bus.key_valid;
    assign key_ok           = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            mix_col_q <= '0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            mix_col_q <= mix_col_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        mix_col_d    = mix_col_q;
        bus.ld_state = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bus.ld_state = 1'b1;
                    round_d      = 4'd0;
                    mix_col_d    = '0;
                    state_d      = S_ARK0;
                end
            end
            S_ARK0: begin
                if (key_ok) begin
                    round_d = 4'd1;
                    state_d = S_SUB;
                end
            end
            S_SUB: state_d = S_SHIFT;
            S_SHIFT: begin
                // final round skips MixColumns
                if (round_q < NR_L) state_d = S_MIX;
                else                state_d = S_ARK;
            end
            S_MIX: begin
                if (mix_col_q == MIX_LAST) begin
                    mix_col_d = '0;
                    state_d   = S_ARK;
                end else begin
                    mix_col_d = mix_col_q + 1'b1;
                end
            end
            S_ARK: begin
                if (key_ok) begin
                    if (round_q == NR_L) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_SUB;
                    end
                end
            end
            S_DONE: begin
                round_d = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                round_d   = 4'd0;
                mix_col_d = '0;
                state_d   = S_IDLE;
            end
        endcase

        // abort overrides every transition, but an idle sequencer has nothing to abort
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            round_d   = 4'd0;
            mix_col_d = '0;
        end
    end

    always_comb begin
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        bus.round    = round_q;
        bus.sub_en   = (state_q == S_SUB);
        bus.shift_en = (state_q == S_SHIFT);
        bus.mix_en   = (state_q == S_MIX);
        bus.mix_col  = mix_col_q;
        bus.ark_en   = ((state_q == S_ARK0) || (state_q == S_ARK)) && key_ok;
`ifdef AES_KEY_WAIT_EN
        bus.key_req  = (state_q == S_ARK0) || (state_q == S_ARK);
`else
        bus.key_req  = 1'b0;
`endif
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: cycle table plus multi-cycle sequences.
module tb_aes_round_sequencer;
    localparam int NR  = 10;
    localparam int MIX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_sequencer_if #(.MIX_CYCLES(MIX)) bus();

    aes_round_sequencer #(.NR(NR), .MIX_CYCLES(MIX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   kdelay = 0;
    int   kw     = 0;
    int   mix_cnt, busy_cnt;
    logic saw_sub10, saw_shift10, saw_ark10, saw_mix10;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic b, input logic d, input logic [3:0] r,
                                       input logic ld, input logic s, input logic sh,
                                       input logic m, input logic [1:0] c, input logic a);
        return {b, d, r, ld, s, sh, m, c, a};
    endfunction

    function automatic logic [12:0] pack();
        return {bus.busy, bus.done, bus.round, bus.ld_state, bus.sub_en, bus.shift_en,
                bus.mix_en, bus.mix_col, bus.ark_en};
    endfunction

    task automatic drive_key();
`ifdef AES_KEY_WAIT_EN
        if (bus.key_req) begin
            bus.key_valid = (kw >= kdelay);
            kw++;
        end else begin
            kw = 0;
            bus.key_valid = 1'b0;
        end
`else
        bus.key_valid = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_key();
        #1;
    endtask

    task automatic monitor();
        logic       prev_busy = 1'b0;
        logic [3:0] prev_round = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
            end else begin
                chk("onehot_en", int'($countones({bus.sub_en, bus.shift_en, bus.mix_en, bus.ark_en}) <= 1), 1);
                chk("round_range", int'(bus.round <= 4'(NR)), 1);
                if (bus.busy && prev_busy)
                    chk("round_monotonic", int'((bus.round == prev_round) || (bus.round == prev_round + 4'd1)), 1);
                if (bus.ld_state)
                    chk("ld_while_busy", int'(bus.busy), 0);
`ifdef AES_KEY_WAIT_EN
                chk("ark_without_key", int'(bus.ark_en & ~bus.key_valid), 0);
`else
                chk("key_req_tied", int'(bus.key_req), 0);
`endif
                prev_busy  = bus.busy;
                prev_round = bus.round;
            end
        end
    endtask

    task automatic run_one(input string nm, input int exp_lat);
        int lat = -1;
        mix_cnt = 0;
        busy_cnt = 0;
        {saw_sub10, saw_shift10, saw_ark10, saw_mix10} = 4'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.mix_en) begin
                chk({nm, "_mix_col"}, int'(bus.mix_col), mix_cnt % MIX);
                mix_cnt++;
            end
            if (bus.round == 4'(NR)) begin
                saw_sub10   |= bus.sub_en;
                saw_shift10 |= bus.shift_en;
                saw_ark10   |= bus.ark_en;
                saw_mix10   |= bus.mix_en;
            end
            step();
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_cycles"}, busy_cnt, exp_lat);
        step();
        chk({nm, "_done_one_cycle"}, int'({bus.done, bus.busy}), 0);
    endtask

    initial begin
        int first_ld, second_ld, extra_ld;
        bit found;
        bit seen_done;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.key_valid = 1'b0;
        rst_n = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'({bus.key_req, pack()}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // cycle table: start, walk round 1, abort, start+abort in IDLE, abort in ARK0
        vecs.push_back('{1'b1, 1'b0, mk(0,0,4'd0,1,0,0,0,2'd0,0)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd0,0,0,0,0,2'd0,1)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd1,0,1,0,0,2'd0,0)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd1,0,0,1,0,2'd0,0)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd1,0,0,0,1,2'd0,0)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd1,0,0,0,1,2'd1,0)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd1,0,0,0,1,2'd2,0)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd1,0,0,0,1,2'd3,0)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd1,0,0,0,0,2'd0,1)});
        vecs.push_back('{1'b0, 1'b0, mk(1,0,4'd2,0,1,0,0,2'd0,0)});
        vecs.push_back('{1'b1, 1'b0, mk(1,0,4'd2,0,0,1,0,2'd0,0)});
        vecs.push_back('{1'b0, 1'b1, mk(1,0,4'd2,0,0,0,1,2'd0,0)});
        vecs.push_back('{1'b0, 1'b1, mk(0,0,4'd0,0,0,0,0,2'd0,0)});
        vecs.push_back('{1'b1, 1'b1, mk(0,0,4'd0,1,0,0,0,2'd0,0)});
        vecs.push_back('{1'b0, 1'b1, mk(1,0,4'd0,0,0,0,0,2'd0,1)});
        vecs.push_back('{1'b0, 1'b0, mk(0,0,4'd0,0,0,0,0,2'd0,0)});

        foreach (vecs[i]) begin
            bus.start = vecs[i].start;
            bus.abort = vecs[i].abort;
            bus.key_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d", i), int'(pack()), int'(vecs[i].exp));
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step();

        // full encryption with default parameters
        kdelay = 0;
        run_one("full", 68);
        chk("full_mix_cycles", mix_cnt, (NR - 1) * MIX);
        chk("full_last_round_stages", int'({saw_sub10, saw_shift10, saw_ark10, saw_mix10}), 4'b1110);

        // start held high: next load in the cycle after done, none while busy
        first_ld = -1;
        second_ld = -1;
        extra_ld = 0;
        bus.key_valid = 1'b1;
        bus.start = 1'b1;
        for (int c = 0; c < 138; c++) begin
            @(negedge clk);
            if (bus.ld_state) begin
                if (first_ld < 0)       first_ld = c;
                else if (second_ld < 0) second_ld = c;
                else                    extra_ld++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_first_ld", first_ld, 0);
        chk("b2b_second_ld", second_ld, 69);
        chk("b2b_extra_ld", extra_ld, 0);
        step();
        step();
        chk("b2b_idle", int'(bus.busy), 0);

        // abort in round 3 SHIFT
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        found = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.shift_en && bus.round == 4'd3) begin
                found = 1'b1;
                break;
            end
            seen_done |= bus.done;
            step();
        end
        chk("abort_reach_shift_r3", int'(found), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_to_idle", int'({bus.busy, bus.round, bus.mix_col}), 0);
        for (int c = 0; c < 5; c++) begin
            seen_done |= bus.done;
            step();
        end
        chk("abort_no_done", int'(seen_done), 0);
        run_one("after_abort", 68);

        // asynchronous reset while in MIX of round 5
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.mix_en && bus.round == 4'd5) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("rst_reach_mix_r5", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mix_outputs", int'({bus.key_req, pack()}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_stays_idle", int'(bus.busy), 0);

`ifdef AES_KEY_WAIT_EN
        kdelay = 2;
        run_one("key_wait", 68 + 2 * (NR + 1));
        chk("key_wait_mix_cycles", mix_cnt, (NR - 1) * MIX);
        kdelay = 0;
`else
        run_one("key_valid_ignored", 68);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
